// File: rtl/hysteresis_pkg.sv
// rtl/hysteresis_pkg.sv - shared types for the time-multiplexed hysteresis switch scanner
package hysteresis_pkg;

  localparam int HYST_W = 16;

  typedef struct packed {
    logic              output_level;
    logic [HYST_W-1:0] cycles_diff;
    logic [HYST_W-1:0] period_counter;
  } t_hyst_state;

  typedef enum logic [0:0] {
    SCAN_IDLE   = 1'b0,
    SCAN_ACTIVE = 1'b1
  } t_scan_fsm;

endpackage

// File: rtl/hysteresis_step.sv
// rtl/hysteresis_step.sv - combinational single-channel hysteresis update
module hysteresis_step
  import hysteresis_pkg::*;
(
  input  t_hyst_state       cur,
  input  logic              x,
  input  logic [HYST_W-1:0] filter_level,
  input  logic [HYST_W-1:0] filter_period,
  output t_hyst_state       nxt,
  output logic              toggle
);

  logic              expired;
  logic [HYST_W-1:0] base;
  logic [HYST_W:0]   sum17;

  always_comb begin
    expired = (cur.period_counter == '0);
    // Arithmetic halving of the difference once per filter period (rounds toward -inf).
    base    = expired ? {cur.cycles_diff[HYST_W-1], cur.cycles_diff[HYST_W-1:1]} : cur.cycles_diff;
    // Threshold compare against the pre-update difference, sign taken from bit 16.
    sum17   = (cur.output_level ? {1'b0, filter_level} : {1'b1, ~filter_level})
            + {cur.cycles_diff[HYST_W-1], cur.cycles_diff};
    toggle  = (sum17[HYST_W] == cur.output_level);

    nxt.period_counter = expired ? filter_period : cur.period_counter - HYST_W'(1);
    nxt.cycles_diff    = x ? base + HYST_W'(1) : base - HYST_W'(1);
    nxt.output_level   = cur.output_level ^ toggle;
  end

endmodule

// File: rtl/hysteresis_switch_scanner.sv
// rtl/hysteresis_switch_scanner.sv - prescaled scan of N switch channels through one hysteresis engine
module hysteresis_switch_scanner
  import hysteresis_pkg::*;
#(
  parameter int N_CHANNELS = 8,
  parameter int CH_W       = $clog2(N_CHANNELS)
) (
  input  logic                  clk,
  input  logic                  clk__enable,
  input  logic                  reset_n,
  input  logic [N_CHANNELS-1:0] input_values,
  input  logic [HYST_W-1:0]     filter_level,
  input  logic [HYST_W-1:0]     filter_period,
  input  logic [HYST_W-1:0]     sample_divider,
  input  logic                  overrun_clear,
  output logic [N_CHANNELS-1:0] output_values,
  output logic [N_CHANNELS-1:0] output_changed,
  output logic                  scan_busy,
  output logic                  overrun
);

  logic [N_CHANNELS-1:0] sync_0;
  logic [N_CHANNELS-1:0] sync_1;
  logic [HYST_W-1:0]     presc;
  logic                  tick;
  t_scan_fsm             fsm;
  logic [CH_W-1:0]       ch;
  t_hyst_state           chan_state [N_CHANNELS];
  t_hyst_state           step_next;
  logic                  step_toggle;

  // Metastability synchroniser carries no reset; it refills within two enabled clocks.
  always_ff @(posedge clk) begin
    if (clk__enable) begin
      sync_0 <= input_values;
      sync_1 <= sync_0;
    end
  end

  assign tick      = (presc == '0);
  assign scan_busy = (fsm == SCAN_ACTIVE);

  hysteresis_step u_step (
    .cur           (chan_state[ch]),
    .x             (sync_1[ch]),
    .filter_level  (filter_level),
    .filter_period (filter_period),
    .nxt           (step_next),
    .toggle        (step_toggle)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc          <= '0;
      fsm            <= SCAN_IDLE;
      ch             <= '0;
      overrun        <= 1'b0;
      output_changed <= '0;
      for (int i = 0; i < N_CHANNELS; i++) begin
        chan_state[i] <= '0;
      end
    end else if (clk__enable) begin
      presc <= tick ? sample_divider : presc - HYST_W'(1);

      // A dropped tick wins over a simultaneous clear.
      if (tick && fsm == SCAN_ACTIVE) begin
        overrun <= 1'b1;
      end else if (overrun_clear) begin
        overrun <= 1'b0;
      end

      output_changed <= '0;
      case (fsm)
        SCAN_IDLE: begin
          if (tick) begin
            fsm <= SCAN_ACTIVE;
            ch  <= '0;
          end
        end
        SCAN_ACTIVE: begin
          chan_state[ch]     <= step_next;
          output_changed[ch] <= step_toggle;
          if (ch == CH_W'(N_CHANNELS - 1)) begin
            fsm <= SCAN_IDLE;
          end else begin
            ch <= ch + CH_W'(1);
          end
        end
        default: fsm <= SCAN_IDLE;
      endcase
    end
  end

  always_comb begin
    output_values = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      output_values[i] = chan_state[i].output_level;
    end
  end

endmodule
